// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response channel for the fetch stage.
// master: fetch unit (issues requests); slave: instruction memory.
interface if_fetch_unit_if;
    logic        imem_req_valid_out;
    logic [31:0] imem_req_addr_out;
    logic        imem_req_ready_in;
    logic        imem_resp_valid_in;
    logic [31:0] imem_resp_data_in;

    modport master (
        output imem_req_valid_out,
        output imem_req_addr_out,
        input  imem_req_ready_in,
        input  imem_resp_valid_in,
        input  imem_resp_data_in
    );

    modport slave (
        input  imem_req_valid_out,
        input  imem_req_addr_out,
        output imem_req_ready_in,
        output imem_resp_valid_in,
        output imem_resp_data_in
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Fetch stage: one outstanding imem read, next-PC/write-enable to the PC
// register, and a small FIFO of {instr, pc} toward decode.
// Ports: clk, reset_in (async, active-low); pc_in / pc_next_out /
// pc_write_out to the PC register; redirect_in / redirect_addr_in;
// imem (request/response channel, master side); instr_valid_out /
// instr_out / instr_pc_out / instr_ready_in toward decode.
module if_fetch_unit #(
    parameter int          QUEUE_DEPTH = 2,
    parameter logic [31:0] PC_STEP     = 32'd4
) (
    input  logic        clk,
    input  logic        reset_in,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next_out,
    output logic        pc_write_out,
    input  logic        redirect_in,
    input  logic [31:0] redirect_addr_in,
    if_fetch_unit_if.master imem,
    output logic        instr_valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc_out,
    input  logic        instr_ready_in
);

    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_left;
    logic [31:0]   req_pc;
    logic [31:0]   data_mem [QUEUE_DEPTH];
    logic [31:0]   pc_mem   [QUEUE_DEPTH];

    logic can_issue;
    logic accept;
    logic resp;
    logic push;
    logic pop;

    assign resp = imem.imem_resp_valid_in;

    // Issue only with a guaranteed free slot, so a push never overflows.
    assign can_issue = reset_in
                     && (state_q == S_REQ)
                     && (count < CW'(QUEUE_DEPTH))
                     && !redirect_in;
    assign accept = can_issue && imem.imem_req_ready_in;

    // A redirect voids both the response and any decode pop this cycle.
    assign push = (state_q == S_WAIT) && resp && !redirect_in;
    assign pop  = instr_valid_out && instr_ready_in && !redirect_in;

    assign instr_valid_out = (count != '0);

    assign rd_ptr_nxt = pop ? rd_ptr + PW'(1) : rd_ptr;
    assign count_left = count - CW'(pop);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ: begin
                if (accept) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (resp)             state_d = S_REQ;
                else if (redirect_in) state_d = S_DROP;
            end
            S_DROP: begin
                if (resp) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    // Outputs are forced low while reset is held, even the combinational ones.
    always_comb begin
        imem.imem_req_valid_out = can_issue;
        imem.imem_req_addr_out  = reset_in ? pc_in : 32'h0;
        pc_write_out = reset_in && (redirect_in || accept);
        pc_next_out  = 32'h0;
        if (reset_in) begin
            unique case (1'b1)
                redirect_in: pc_next_out = redirect_addr_in;
                accept:      pc_next_out = pc_in + PC_STEP;
                default:     pc_next_out = pc_in;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= S_REQ;
            req_pc  <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) req_pc <= pc_in;
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr_nxt;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                data_mem[i] <= 32'h0;
                pc_mem[i]   <= 32'h0;
            end
        end else if (push) begin
            data_mem[wr_ptr] <= imem.imem_resp_data_in;
            pc_mem[wr_ptr]   <= req_pc;
        end
    end

    // Registered head: bypass the pushed entry when it lands in an
    // otherwise-empty queue; hold the last value when nothing remains.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            instr_out    <= 32'h0;
            instr_pc_out <= 32'h0;
        end else if (!redirect_in) begin
            if (push && count_left == '0) begin
                instr_out    <= imem.imem_resp_data_in;
                instr_pc_out <= req_pc;
            end else if (count_left != '0) begin
                instr_out    <= data_mem[rd_ptr_nxt];
                instr_pc_out <= pc_mem[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: PC register and imem modelled in
// the stimulus flow, per-cycle vector table plus corner sequences.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_in;
    logic [31:0] pc_in;
    logic [31:0] pc_next_out;
    logic        pc_write_out;
    logic        redirect_in;
    logic [31:0] redirect_addr_in;
    logic        instr_valid_out;
    logic [31:0] instr_out;
    logic [31:0] instr_pc_out;
    logic        instr_ready_in;

    if_fetch_unit_if imem ();

    always #5 clk = ~clk;

    if_fetch_unit #(
        .QUEUE_DEPTH(2),
        .PC_STEP    (32'd4)
    ) dut (
        .clk             (clk),
        .reset_in        (reset_in),
        .pc_in           (pc_in),
        .pc_next_out     (pc_next_out),
        .pc_write_out    (pc_write_out),
        .redirect_in     (redirect_in),
        .redirect_addr_in(redirect_addr_in),
        .imem            (imem.master),
        .instr_valid_out (instr_valid_out),
        .instr_out       (instr_out),
        .instr_pc_out    (instr_pc_out),
        .instr_ready_in  (instr_ready_in)
    );

    typedef struct packed {
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_pw;
        logic [31:0] e_pn;
        logic        e_iv;
        logic [31:0] e_ipc;
        logic [31:0] e_ins;
    } vec_t;

    int checks = 0;
    int errors = 0;

    bit          auto_mem;
    int          lat;
    bit          mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;
    logic        man_rv;
    logic [31:0] man_rd;

    logic        s_rv;
    logic [31:0] s_ra;
    logic        s_pw;
    logic [31:0] s_pn;
    logic        s_iv;
    logic [31:0] s_ipc;
    logic [31:0] s_ins;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'h1300_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sample();
        s_rv  = imem.imem_req_valid_out;
        s_ra  = imem.imem_req_addr_out;
        s_pw  = pc_write_out;
        s_pn  = pc_next_out;
        s_iv  = instr_valid_out;
        s_ipc = instr_pc_out;
        s_ins = instr_out;
    endtask

    // One cycle: drive inputs, sample, book-keep imem, clock, update PC reg.
    task automatic step(input logic rdy, input logic ir,
                        input logic redir, input logic [31:0] raddr);
        imem.imem_req_ready_in = rdy;
        instr_ready_in   = ir;
        redirect_in      = redir;
        redirect_addr_in = raddr;
        if (auto_mem) begin
            imem.imem_resp_valid_in = mem_pend && (mem_cnt == 0);
            imem.imem_resp_data_in  =
                (mem_pend && mem_cnt == 0) ? dat(mem_addr) : 32'h0;
        end else begin
            imem.imem_resp_valid_in = man_rv;
            imem.imem_resp_data_in  = man_rd;
        end
        #1;
        sample();
        if (auto_mem) begin
            if (imem.imem_resp_valid_in) mem_pend = 1'b0;
            else if (mem_pend) mem_cnt--;
            if (s_rv && rdy) begin
                mem_pend = 1'b1;
                mem_cnt  = lat - 1;
                mem_addr = s_ra;
            end
        end
        @(posedge clk);
        #1;
        if (s_pw) pc_in = s_pn;
    endtask

    task automatic do_reset(input logic [31:0] pcv);
        reset_in = 1'b0;
        pc_in    = pcv;
        mem_pend = 1'b0;
        mem_cnt  = 0;
        lat      = 1;
        man_rv   = 1'b0;
        man_rd   = 32'h0;
        imem.imem_req_ready_in  = 1'b1;
        imem.imem_resp_valid_in = 1'b1;
        imem.imem_resp_data_in  = 32'hDEAD_BEEF;
        instr_ready_in   = 1'b1;
        redirect_in      = 1'b1;
        redirect_addr_in = 32'h0000_0F00;
        @(posedge clk);
        #1;
        sample();
        chk("rst_req_valid", {31'h0, s_rv}, 32'h0);
        chk("rst_req_addr",  s_ra, 32'h0);
        chk("rst_pc_write",  {31'h0, s_pw}, 32'h0);
        chk("rst_pc_next",   s_pn, 32'h0);
        chk("rst_instr_valid", {31'h0, s_iv}, 32'h0);
        chk("rst_instr_pc",  s_ipc, 32'h0);
        chk("rst_instr",     s_ins, 32'h0);
        redirect_in = 1'b0;
        imem.imem_resp_valid_in = 1'b0;
        reset_in = 1'b1;
    endtask

    vec_t tbl [7];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1,
                   32'h4, 1'b0, 32'h0, 32'h0};
        tbl[1] = '{1'b1, 1'b1, dat(32'h0), 1'b1, 1'b0, 32'h0, 1'b0,
                   32'h4, 1'b0, 32'h0, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b1,
                   32'h8, 1'b1, 32'h0, dat(32'h0)};
        tbl[3] = '{1'b1, 1'b1, dat(32'h4), 1'b1, 1'b0, 32'h0, 1'b0,
                   32'h8, 1'b0, 32'h0, dat(32'h0)};
        tbl[4] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1,
                   32'hC, 1'b1, 32'h4, dat(32'h4)};
        tbl[5] = '{1'b1, 1'b1, dat(32'h8), 1'b1, 1'b0, 32'h0, 1'b0,
                   32'hC, 1'b0, 32'h4, dat(32'h4)};
        tbl[6] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b0,
                   32'hC, 1'b1, 32'h8, dat(32'h8)};

        // Sequential fetch, hand-driven responses of latency 1.
        auto_mem = 1'b0;
        do_reset(32'h0);
        for (int i = 0; i < 7; i++) begin
            man_rv = tbl[i].rv;
            man_rd = tbl[i].rd;
            step(tbl[i].rdy, tbl[i].ir, 1'b0, 32'h0);
            chk($sformatf("t1_req_valid[%0d]", i),
                {31'h0, s_rv}, {31'h0, tbl[i].e_rv});
            if (tbl[i].e_rv)
                chk($sformatf("t1_req_addr[%0d]", i), s_ra, tbl[i].e_ra);
            chk($sformatf("t1_pc_write[%0d]", i),
                {31'h0, s_pw}, {31'h0, tbl[i].e_pw});
            chk($sformatf("t1_pc_next[%0d]", i), s_pn, tbl[i].e_pn);
            chk($sformatf("t1_iv[%0d]", i),
                {31'h0, s_iv}, {31'h0, tbl[i].e_iv});
            chk($sformatf("t1_ipc[%0d]", i), s_ipc, tbl[i].e_ipc);
            chk($sformatf("t1_instr[%0d]", i), s_ins, tbl[i].e_ins);
        end
        man_rv = 1'b0;
        auto_mem = 1'b1;

        // Back-pressure: queue fills, fetch stalls, then drains.
        do_reset(32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            chk("t2_full_req_valid", {31'h0, s_rv}, 32'h0);
            chk("t2_full_pc_write", {31'h0, s_pw}, 32'h0);
            chk("t2_full_iv", {31'h0, s_iv}, 32'h1);
            chk("t2_full_ipc", s_ipc, 32'h0);
        end
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t2_pop0_req_valid", {31'h0, s_rv}, 32'h0);
        chk("t2_pop0_ipc", s_ipc, 32'h0);
        chk("t2_pop0_instr", s_ins, dat(32'h0));
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t2_pop1_req_valid", {31'h0, s_rv}, 32'h1);
        chk("t2_pop1_req_addr", s_ra, 32'h8);
        chk("t2_pop1_ipc", s_ipc, 32'h4);
        chk("t2_pop1_instr", s_ins, dat(32'h4));
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t2_gap_iv", {31'h0, s_iv}, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t2_resume_ipc", s_ipc, 32'h8);
        chk("t2_resume_instr", s_ins, dat(32'h8));

        // Redirect while waiting; stale response arrives two cycles later.
        do_reset(32'h4);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        lat = 3;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("t3_acc8_addr", s_ra, 32'h8);
        step(1'b1, 1'b0, 1'b1, 32'h100);
        chk("t3_redir_pw", {31'h0, s_pw}, 32'h1);
        chk("t3_redir_pn", s_pn, 32'h100);
        chk("t3_redir_req_valid", {31'h0, s_rv}, 32'h0);
        chk("t3_redir_iv", {31'h0, s_iv}, 32'h1);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("t3_flushed_iv", {31'h0, s_iv}, 32'h0);
        chk("t3_drop_req_valid", {31'h0, s_rv}, 32'h0);
        chk("t3_drop_pw", {31'h0, s_pw}, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("t3_stale_req_valid", {31'h0, s_rv}, 32'h0);
        lat = 1;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("t3_new_req_valid", {31'h0, s_rv}, 32'h1);
        chk("t3_new_req_addr", s_ra, 32'h100);
        chk("t3_new_pn", s_pn, 32'h104);
        chk("t3_after_stale_iv", {31'h0, s_iv}, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("t3_first_iv", {31'h0, s_iv}, 32'h1);
        chk("t3_first_ipc", s_ipc, 32'h100);
        chk("t3_first_instr", s_ins, dat(32'h100));

        // Redirect coincides with a response and a decode pop.
        do_reset(32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h200);
        chk("t4_redir_pn", s_pn, 32'h200);
        chk("t4_redir_iv", {31'h0, s_iv}, 32'h1);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t4_count0_iv", {31'h0, s_iv}, 32'h0);
        chk("t4_req_valid", {31'h0, s_rv}, 32'h1);
        chk("t4_req_addr", s_ra, 32'h200);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t4_first_ipc", s_ipc, 32'h200);
        chk("t4_first_instr", s_ins, dat(32'h200));

        // Memory not ready for three cycles.
        do_reset(32'h4);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            chk("t5_stall_valid", {31'h0, s_rv}, 32'h1);
            chk("t5_stall_addr", s_ra, 32'h4);
            chk("t5_stall_pw", {31'h0, s_pw}, 32'h0);
            chk("t5_stall_pn", s_pn, 32'h4);
        end
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t5_acc_pw", {31'h0, s_pw}, 32'h1);
        chk("t5_acc_pn", s_pn, 32'h8);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t5_ipc", s_ipc, 32'h4);
        chk("t5_instr", s_ins, dat(32'h4));

        // Asynchronous reset in S_WAIT with one entry queued.
        do_reset(32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("t6_pre_iv", {31'h0, s_iv}, 32'h1);
        #2;
        reset_in = 1'b0;
        #1;
        sample();
        chk("t6_async_iv", {31'h0, s_iv}, 32'h0);
        chk("t6_async_req_valid", {31'h0, s_rv}, 32'h0);
        chk("t6_async_pw", {31'h0, s_pw}, 32'h0);
        @(posedge clk);
        #1;
        reset_in = 1'b1;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("t6_rel_req_valid", {31'h0, s_rv}, 32'h1);
        chk("t6_rel_req_addr", s_ra, 32'h8);
        chk("t6_rel_iv", {31'h0, s_iv}, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("t6_first_ipc", s_ipc, 32'h8);
        chk("t6_first_instr", s_ins, dat(32'h8));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage directly downstream of the PC register. Reads the current PC, issues one instruction-memory read at a time over a valid/ready request channel, and computes the next PC (PC+PC_STEP or a redirect target) together with the PC write-enable back to the PC register. Fetched instructions and their PCs are buffered in a small FIFO toward decode. Redirects flush the FIFO and drop any in-flight response.

Parameters:
QUEUE_DEPTH, 2, output FIFO entries; power of two, at least 2
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk  input  1  system clock, rising edge
reset_in  input  1  asynchronous, active-low reset
pc_in  input  32  current PC, driven from the PC register output
pc_next_out  output  32  next PC value to the PC register data input
pc_write_out  output  1  PC register write enable
redirect_in  input  1  branch/jump redirect pulse
redirect_addr_in  input  32  redirect target
imem_req_valid_out  output  1  fetch request valid
imem_req_addr_out  output  32  fetch address
imem_req_ready_in  input  1  memory accepts request
imem_resp_valid_in  input  1  read data valid; at least 1 cycle after request accept
imem_resp_data_in  input  32  instruction word
instr_valid_out  output  1  FIFO head valid to decode
instr_out  output  32  head instruction
instr_pc_out  output  32  PC of head instruction
instr_ready_in  input  1  decode consumes head

Behaviour:
- Reset (reset_in low, asynchronous): state=S_REQ, FIFO count=0, pointers=0, req_pc=0, instr_out=0, instr_pc_out=0. While reset_in is low, all outputs are 0, including combinational outputs.
- FSM states:
  - S_REQ: imem_req_valid_out=1 iff count<QUEUE_DEPTH and redirect_in=0. imem_req_addr_out=pc_in.
  - On accept (valid&ready): req_pc<=pc_in, pc_write_out=1, pc_next_out=pc_in+PC_STEP (mod 2^32, 0xFFFFFFFC wraps to 0x0), go to S_WAIT.
  - S_REQ with valid high and ready low: hold valid; address stays stable because pc_write_out=0.
  - S_WAIT: imem_req_valid_out=0. On imem_resp_valid_in, push {imem_resp_data_in, req_pc} and go to S_REQ.
  - S_DROP: awaiting the stale response after a redirect. On imem_resp_valid_in, discard it and go to S_REQ.
  - imem_resp_valid_in is ignored in S_REQ.
- Redirect (redirect_in=1, any state):
  - Outputs: pc_write_out=1, pc_next_out=redirect_addr_in. Redirect has priority over PC+PC_STEP.
  - FIFO: count, rd_ptr and wr_ptr are cleared at the next edge. A same-cycle pop is void. A same-cycle push is suppressed.
  - Next state from S_REQ: stay in S_REQ. No request is issued that cycle.
  - Next state from S_WAIT: S_DROP if there is no response that cycle; S_REQ if a response arrives that cycle (the response is discarded).
  - Next state from S_DROP: S_DROP, or S_REQ if a response arrives that cycle (discarded).
- When neither accept nor redirect occurs: pc_write_out=0 and pc_next_out=pc_in.
- Issue rule: at most one outstanding request. The issue gate count<QUEUE_DEPTH guarantees a free slot, so a push never overflows.
- FIFO:
  - instr_valid_out=(count!=0). Head data is registered storage.
  - Pop on instr_valid_out&instr_ready_in.
  - Simultaneous push and pop keeps count unchanged. Pointers wrap modulo QUEUE_DEPTH.
  - When empty, instr_out and instr_pc_out hold their last values.
- Latency:
  - Request accept at edge N.
  - Earliest response in cycle N+1, pushed at edge N+1.
  - instr_valid_out rises in cycle N+2.
  - Next request can be issued in cycle N+2.
  - Peak throughput is one instruction per 2 cycles.

Test Plan:
1. Release reset; PC register at 0; imem ready=1, response latency 1; instr_ready=1 -> requests to 0x0, 0x4, 0x8; instr_pc_out 0x0, 0x4, 0x8 in order with matching data; pc_write_out pulses once per accept.
2. instr_ready=0 from start -> after 2 instructions count=2, imem_req_valid_out stays 0, pc_write_out 0; raise instr_ready -> pops 0x0 then 0x4, fetch resumes at 0x8.
3. Redirect to 0x100 in S_WAIT for 0x8, response 2 cycles later -> FIFO empty next cycle, response for 0x8 discarded, next request address 0x100, first delivered instr_pc_out 0x100.
4. Redirect to 0x200 in the same cycle as the response and a decode pop -> nothing pushed, count=0, next request at 0x200.
5. imem_req_ready_in=0 for 3 cycles at PC 0x4 -> valid held, address 0x4 stable, pc_write_out=0; accepted on cycle 4.
6. Drop reset_in mid-edge while in S_WAIT with 1 entry queued -> instr_valid_out and imem_req_valid_out go 0 immediately; a late response after release is ignored (S_REQ); first request after release is at the current pc_in.
